// File: rtl/audio_pkg.sv
// Shared types and helpers for the serial audio output path.
// PCM mapping of the square level lives here so other audio blocks can reuse it.
package audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  localparam int          DEF_SAMPLE_W  = 16;
  localparam logic [31:0] DEF_AMPLITUDE = 32'h0000_2000;

  // Result is 32-bit two's complement; callers truncate to their slot width.
  function automatic logic [31:0] level_to_pcm(input logic        level,
                                               input logic        mute,
                                               input logic [31:0] amp = DEF_AMPLITUDE);
    if (mute) return '0;
    return level ? amp : (~amp + 32'd1);
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// BCLK divider: free-running div_cnt, registered bclk and a falling-event strobe.
// The synchronous clear parks everything at zero while the transmitter is idle.
module i2s_clk_div #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bclk,
  output logic fall
);

  localparam int            DW   = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;

  assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
  // Asserted in the cycle whose closing edge wraps div_cnt, i.e. BCLK falls.
  assign fall    = !clear && (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      bclk    <= (div_nxt >= HALF);
    end
  end

endmodule

// File: rtl/square_i2s_tx.sv
// Philips I2S transmitter for the square-wave test path: both channels carry
// a fixed-amplitude PCM sample chosen from square_in/mute at every frame start.
//
//   state | meaning
//   IDLE  | all outputs and counters held at 0, waiting for enable
//   RUN   | streaming frames; a pending stop ends RUN at the next frame end
module square_i2s_tx
  import audio_pkg::*;
#(
  parameter int                  CLK_DIV   = 32,
  parameter int                  SAMPLE_W  = DEF_SAMPLE_W,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE = SAMPLE_W'(DEF_AMPLITUDE)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic square_in,
  input  logic enable,
  input  logic mute,
  output logic bclk,
  output logic lrclk,
  output logic sdata,
  output logic sample_strobe
);

  localparam int            FW        = 2 * SAMPLE_W;
  localparam int            BW        = $clog2(FW);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
  localparam logic [BW-1:0] RIGHT_BIT = BW'(SAMPLE_W);

  i2s_state_t          state, state_nxt;
  logic                fall, frame_end, load, stop_pend;
  logic [BW-1:0]       bit_cnt, bit_nxt;
  logic [FW-1:0]       frame_sr;
  logic [SAMPLE_W-1:0] sample;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .bclk  (bclk),
    .fall  (fall)
  );

  assign sample    = SAMPLE_W'(level_to_pcm(square_in, mute, 32'(AMPLITUDE)));
  assign bit_nxt   = bit_cnt + 1'b1;
  assign frame_end = fall && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (stop_pend || !enable) state_nxt = IDLE;
          else                      load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame register shifts MSB-first; after FW-1 shifts its MSB is the old right LSB,
  // which is exactly what the one-bit delay puts out in the next frame's slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= '0;
      frame_sr      <= '0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      sample_strobe <= 1'b0;
      stop_pend     <= 1'b0;
    end else if (state_nxt == IDLE) begin
      bit_cnt       <= '0;
      frame_sr      <= '0;
      lrclk         <= 1'b0;
      sdata         <= 1'b0;
      sample_strobe <= 1'b0;
      stop_pend     <= 1'b0;
    end else begin
      sample_strobe <= load;
      if (state == RUN && !enable) stop_pend <= 1'b1;
      if (load) begin
        bit_cnt  <= '0;
        lrclk    <= 1'b0;
        frame_sr <= {sample, sample};
        sdata    <= (state == RUN) ? frame_sr[FW-1] : 1'b0;
      end else if (fall) begin
        bit_cnt  <= bit_nxt;
        lrclk    <= (bit_nxt >= RIGHT_BIT);
        sdata    <= frame_sr[FW-1];
        frame_sr <= {frame_sr[FW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_square_i2s_tx.sv
// Bench for square_i2s_tx: cycle-exact frame-timing reference model, serial word
// decoder, a table of level/mute vectors and hand-written stop/reset sequences.
module tb_square_i2s_tx;

  localparam int          CD    = 4;
  localparam int          SW    = 16;
  localparam int          FRAME = 2 * SW * CD;
  localparam logic [15:0] AMP   = 16'h2000;

  logic clk = 1'b0;
  logic rst_n, square_in, enable, mute;
  logic bclk, lrclk, sdata, sample_strobe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  square_i2s_tx #(.CLK_DIV(CD), .SAMPLE_W(SW), .AMPLITUDE(AMP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .square_in     (square_in),
    .enable        (enable),
    .mute          (mute),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  // Reference model: time since frame start, current word, previous right LSB.
  bit          m_run  = 1'b0;
  bit          m_stop = 1'b0;
  bit          m_prev = 1'b0;
  int          m_t    = 0;
  logic [15:0] m_word = '0;

  function automatic logic [15:0] ref_pcm(input logic sq, input logic mu);
    if (mu) return 16'h0000;
    return sq ? AMP : 16'(32'h10000 - 32'(AMP));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_stop = 1'b0; m_prev = 1'b0; m_t = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; m_stop = 1'b0; m_prev = 1'b0; m_t = 0;
        m_word = ref_pcm(square_in, mute);
      end
    end else begin
      if (!enable) m_stop = 1'b1;
      m_t++;
      if (m_t == FRAME) begin
        if (m_stop) m_run = 1'b0;
        else begin
          m_t    = 0;
          m_prev = m_word[0];
          m_word = ref_pcm(square_in, mute);
        end
      end
    end
  end

  // {bclk, lrclk, sdata, sample_strobe}
  function automatic logic [3:0] model_out();
    int   pos, slot;
    logic sd;
    if (!m_run) return 4'b0000;
    pos  = m_t % CD;
    slot = m_t / CD;
    if (slot == 0) sd = m_prev;
    else           sd = m_word[(2 * SW - slot) % SW];
    return {pos >= CD / 2, slot >= SW, sd, m_t == 0};
  endfunction

  logic [15:0] left_q[$];
  logic [15:0] right_q[$];
  logic [15:0] dsr   = '0;
  logic        dprev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_strobe(output int at);
    at = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (sample_strobe) begin
        at = cyc;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL strobe_timeout: got no sample_strobe expected one within %0d clk", 3 * FRAME);
  endtask

  task automatic lrclk_fall(output int at);
    logic prev;
    at   = -1;
    prev = lrclk;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (prev && !lrclk) begin
        at = cyc;
        return;
      end
      prev = lrclk;
    end
    checks++;
    failures++;
    $display("FAIL lrclk_timeout: got no lrclk fall expected one within %0d clk", 3 * FRAME);
  endtask

  function automatic logic [31:0] pop_left();
    if (left_q.size() == 0) return 32'h0001_0000;
    return {16'h0, left_q.pop_front()};
  endfunction

  function automatic logic [31:0] pop_right();
    if (right_q.size() == 0) return 32'h0001_0000;
    return {16'h0, right_q.pop_front()};
  endfunction

  function automatic void flush();
    left_q.delete();
    right_q.delete();
    dprev = lrclk;
  endfunction

  task automatic check_frame_words(input string name, input logic [15:0] exp);
    check({name, "_left"},  pop_left(),  {16'h0, exp});
    check({name, "_right"}, pop_right(), {16'h0, exp});
  endtask

  typedef struct {
    logic        sq;
    logic        mu;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int a, b, c, n;

    vecs[0] = '{1'b1, 1'b0, 16'h2000};
    vecs[1] = '{1'b0, 1'b0, 16'hE000};
    vecs[2] = '{1'b0, 1'b1, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h2000};
    vecs[5] = '{1'b0, 1'b0, 16'hE000};

    rst_n = 1'b0; enable = 1'b0; square_in = 1'b0; mute = 1'b0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        check("cycle_outputs", {28'h0, bclk, lrclk, sdata, sample_strobe}, {28'h0, model_out()});
      end
      forever begin
        @(posedge bclk);
        dsr = {dsr[14:0], sdata};
        if (lrclk && !dprev) left_q.push_back(dsr);
        if (!lrclk && dprev) right_q.push_back(dsr);
        dprev = lrclk;
      end
    join_none

    // Reset and idle with enable low
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample_strobe) n++;
    end
    check("idle_no_strobe", n, 0);
    check("idle_outputs", {28'h0, bclk, lrclk, sdata, sample_strobe}, 32'h0);

    // Streaming and lrclk period
    enable = 1'b1; square_in = 1'b1;
    wait_strobe(a);
    lrclk_fall(a);
    lrclk_fall(b);
    check("lrclk_period", b - a, FRAME);

    // Table of level/mute vectors
    foreach (vecs[i]) begin
      square_in = vecs[i].sq;
      mute      = vecs[i].mu;
      wait_strobe(a);
      repeat (4) @(negedge clk);
      flush();
      wait_strobe(a);
      repeat (4) @(negedge clk);
      check_frame_words($sformatf("vec%0d", i), vecs[i].word);
    end

    // Mid-frame change of square_in and strobe period
    square_in = 1'b1; mute = 1'b0;
    wait_strobe(a);
    wait_strobe(a);
    repeat (5 * CD) @(negedge clk);
    square_in = 1'b0;
    flush();
    wait_strobe(b);
    repeat (4) @(negedge clk);
    check_frame_words("midchange_cur", 16'h2000);
    flush();
    wait_strobe(c);
    repeat (4) @(negedge clk);
    check_frame_words("midchange_next", 16'hE000);
    check("strobe_period_1", b - a, FRAME);
    check("strobe_period_2", c - b, FRAME);

    // Stop request mid-frame
    wait_strobe(a);
    repeat (3 * CD) @(negedge clk);
    enable = 1'b0;
    repeat (FRAME - 1 - 3 * CD) @(negedge clk);
    check("stop_last_slot", {30'h0, bclk, lrclk}, 32'h3);
    @(negedge clk);
    check("stop_idle", {28'h0, bclk, lrclk, sdata, sample_strobe}, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_strobe || bclk) n++;
    end
    check("stop_stays_idle", n, 0);
    enable = 1'b1;
    wait_strobe(a);
    n = 0;
    for (int i = 0; i < CD; i++) begin
      if (sdata) n++;
      @(negedge clk);
    end
    check("restart_slot0_sdata", n, 0);

    // Async reset in the right slot
    square_in = 1'b1;
    wait_strobe(a);
    repeat (20 * CD) @(negedge clk);
    check("pre_reset_lrclk", {31'h0, lrclk}, 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {28'h0, bclk, lrclk, sdata, sample_strobe}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
    wait_strobe(a);
    repeat (4) @(negedge clk);
    flush();
    wait_strobe(a);
    repeat (4) @(negedge clk);
    check_frame_words("after_reset", 16'h2000);

    // Randomized levels, mute and enable against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) square_in = ~square_in;
      if ($urandom_range(0, 79) == 0) mute = ~mute;
      if (enable && $urandom_range(0, 599) == 0)       enable = 1'b0;
      else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
